// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter and its round-robin picker.
package ram_arbiter_pkg;

  // Lock FSM encoding: IDLE arbitrates freely, OWNx reserves the RAM for master x.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Master indices into the req/gnt/rd_owner vectors.
  localparam int M0 = 0;
  localparam int M1 = 1;

  // Byte-address bits below the RAM word address.
  localparam int BYTE_OFS = 2;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a lone requester wins, and on a tie the master
// that was not granted last wins. Purely combinational.
module arb_rr2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // One-hot grant; last_i = 1 means M1 was granted last, so M0 wins a tie.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[M0] && (!req_i[M1] || last_i)) begin
      gnt_o[M0] = 1'b1;
    end else if (req_i[M1]) begin
      gnt_o[M1] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port, byte-lane data RAM between the core data port (m0)
// and the debug/loader master (m1). Round-robin arbitration with a bounded
// bus lock; read ownership is registered so each returning word reaches the
// master that issued the read.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int RAM_AW   = 10,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_be,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_be,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,

  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  // A zero LOCK_MAX disables locking; keep the counter one bit wide then.
  localparam int               CNT_W      = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
  localparam bit               LOCK_EN    = (LOCK_MAX > 0);

  arb_state_e       state_q,    state_d;
  logic             last_q,     last_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]       rd_owner_q, rd_owner_d;

  logic [1:0] req;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic       owned;
  logic       owner;
  logic       forced;
  logic       free_arb;
  logic       pick_last;
  logic       sel;
  logic       any_gnt;
  logic       sel_we;
  logic       sel_lock;
  logic [3:0] sel_be;

  // Only the word-address bits reach the RAM; misaligned bytes are ignored.
  logic unused_addr;
  assign unused_addr = ^{m0_addr[ADDR_W-1:RAM_AW+BYTE_OFS], m0_addr[BYTE_OFS-1:0],
                         m1_addr[ADDR_W-1:RAM_AW+BYTE_OFS], m1_addr[BYTE_OFS-1:0]};

  // Lock bookkeeping: when the owner hits LOCK_MAX or stops requesting, the
  // cycle falls back to free arbitration with the other master favoured.
  always_comb begin
    req       = {m1_req, m0_req};
    owned     = (state_q == OWN0) || (state_q == OWN1);
    owner     = (state_q == OWN1);
    forced    = owned && (lock_cnt_q == LOCK_MAX_C);
    free_arb  = !owned || forced || !req[owner];
    pick_last = forced ? owner : last_q;
  end

  arb_rr2 u_rr (
    .req_i  (req),
    .last_i (pick_last),
    .gnt_o  (rr_gnt)
  );

  // Final grant and the RAM request mux; everything is suppressed in reset.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (free_arb) begin
        gnt = rr_gnt;
      end else begin
        gnt[owner] = 1'b1;
      end
    end
    any_gnt   = |gnt;
    sel       = gnt[M1];
    sel_we    = sel ? m1_we   : m0_we;
    sel_be    = sel ? m1_be   : m0_be;
    sel_lock  = sel ? m1_lock : m0_lock;
    ram_en    = any_gnt;
    ram_we    = (any_gnt && sel_we) ? sel_be : 4'b0000;
    ram_addr  = sel ? m1_addr[RAM_AW+BYTE_OFS-1:BYTE_OFS] : m0_addr[RAM_AW+BYTE_OFS-1:BYTE_OFS];
    ram_wdata = sel ? m1_wdata : m0_wdata;
    m0_gnt    = gnt[M0];
    m1_gnt    = gnt[M1];
  end

  // Next state: lock entry only from free arbitration, except that the owner
  // just forced off cannot immediately re-lock in the release cycle.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    rd_owner_d = 2'b00;
    if (any_gnt) begin
      last_d = sel;
      if (!sel_we) begin
        rd_owner_d = gnt;
      end
      if (free_arb) begin
        if (LOCK_EN && sel_lock && !(forced && (sel == owner))) begin
          state_d    = sel ? OWN1 : OWN0;
          lock_cnt_d = CNT_W'(1);
        end else begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end
      end else if (sel_lock) begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end else begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    end else begin
      state_d    = IDLE;
      lock_cnt_d = '0;
    end
  end

  // State registers; reset also drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rd_owner_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Read return: route the RAM word to the recorded owner, zero elsewhere.
  always_comb begin
    m0_rvalid = rd_owner_q[M0] && !rst;
    m1_rvalid = rd_owner_q[M1] && !rst;
    m0_rdata  = m0_rvalid ? ram_rdata : 32'h0;
    m1_rdata  = m1_rvalid ? ram_rdata : 32'h0;
  end

endmodule
